// File: rtl/reference_router_wrapper_if.sv
// Routed-packet result bus and counter readback port of reference_router_wrapper.
`timescale 1ns/1ps
interface reference_router_wrapper_if #(
  parameter int CNT_W = 16
);
  logic             route_valid;
  logic [4:0]       route_port;
  logic [31:0]      route_dst;
  logic [2:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_value;

  modport master (
    output route_valid, route_port, route_dst, cnt_value,
    input  cnt_sel
  );

  modport slave (
    input  route_valid, route_port, route_dst, cnt_value,
    output cnt_sel
  );
endinterface

// File: rtl/reference_router_wrapper.sv
// Self-driven packet generator feeding a fixed LPM route table, with saturating statistics.
// Optional heartbeat LED toggling every 16 routed packets: define REFROUTER_HEARTBEAT_EN.
`timescale 1ns/1ps
module reference_router_wrapper #(
  parameter int          GAP       = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic                              fpga_sysclk_p,
  input  logic                              fpga_sysclk_n,
  input  logic                              reset,
  reference_router_wrapper_if.master        rt,
  output logic                              led_heartbeat
);

  localparam logic [15:0]      GAP_LAST = 16'(GAP - 1);
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Differential complement is not needed; the design runs on the positive leg only.
  logic unused_sysclk_n;
  assign unused_sysclk_n = fpga_sysclk_n;

  function automatic logic [15:0] template_hi(input logic [2:0] k);
    case (k)
      3'd0:    template_hi = 16'h0A02;
      3'd1:    template_hi = 16'h0A01;
      3'd2:    template_hi = 16'hC0A8;
      3'd3:    template_hi = 16'hAC1F;
      default: template_hi = 16'h0808;
    endcase
  endfunction

  // Longest prefixes are tested first so the most specific route wins.
  function automatic logic [4:0] lookup(input logic [15:0] hi);
    if (hi == 16'h0A01)             lookup = 5'b00010;
    else if (hi == 16'hC0A8)        lookup = 5'b00100;
    else if (hi[15:4] == 12'hAC1)   lookup = 5'b01000;
    else if (hi[15:8] == 8'h0A)     lookup = 5'b00001;
    else                            lookup = 5'b10000;
  endfunction

  logic [15:0]      gap_q, gap_d;
  logic             gen_q, gen_d;
  logic [2:0]       k_q, k_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             v1_q, v1_d;
  logic [31:0]      dst1_q, dst1_d;
  logic             valid_q, valid_d;
  logic [4:0]       port_q, port_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];

  always_comb begin
    gap_d  = (gap_q == GAP_LAST) ? 16'd0 : gap_q + 16'd1;
    gen_d  = (gap_q == GAP_LAST);
    k_d    = k_q;
    lfsr_d = lfsr_q;
    v1_d   = gen_q;
    dst1_d = '0;
    if (gen_q) begin
      dst1_d = {template_hi(k_q), lfsr_q};
      k_d    = (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    valid_d = v1_q;
    port_d  = v1_q ? lookup(dst1_q[31:16]) : 5'b00000;
    dst_d   = v1_q ? dst1_q : 32'h0;
  end

  always_comb begin
    for (int i = 0; i < 6; i++) cnt_d[i] = cnt_q[i];
    if (valid_q) begin
      for (int i = 0; i < 5; i++)
        if (port_q[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
      if (cnt_q[5] != CNT_MAX) cnt_d[5] = cnt_q[5] + 1'b1;
    end
  end

  always_ff @(posedge fpga_sysclk_p) begin
    if (!reset) begin
      gap_q   <= '0;
      gen_q   <= 1'b0;
      k_q     <= '0;
      lfsr_q  <= SEED;
      v1_q    <= 1'b0;
      dst1_q  <= '0;
      valid_q <= 1'b0;
      port_q  <= '0;
      dst_q   <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      gap_q   <= gap_d;
      gen_q   <= gen_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      v1_q    <= v1_d;
      dst1_q  <= dst1_d;
      valid_q <= valid_d;
      port_q  <= port_d;
      dst_q   <= dst_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    case (rt.cnt_sel)
      3'd0:    rt.cnt_value = cnt_q[0];
      3'd1:    rt.cnt_value = cnt_q[1];
      3'd2:    rt.cnt_value = cnt_q[2];
      3'd3:    rt.cnt_value = cnt_q[3];
      3'd4:    rt.cnt_value = cnt_q[4];
      3'd5:    rt.cnt_value = cnt_q[5];
      default: rt.cnt_value = '0;
    endcase
  end

  assign rt.route_valid = valid_q;
  assign rt.route_port  = port_q;
  assign rt.route_dst   = dst_q;

`ifdef REFROUTER_HEARTBEAT_EN
  logic [3:0] hb_q, hb_d;
  logic       led_q, led_d;

  always_comb begin
    hb_d  = hb_q;
    led_d = led_q;
    if (valid_q) begin
      hb_d = hb_q + 4'd1;
      if (hb_q == 4'd15) led_d = ~led_q;
    end
  end

  always_ff @(posedge fpga_sysclk_p) begin
    if (!reset) begin
      hb_q  <= '0;
      led_q <= 1'b0;
    end else begin
      hb_q  <= hb_d;
      led_q <= led_d;
    end
  end

  assign led_heartbeat = led_q;
`else
  assign led_heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_reference_router_wrapper.sv
// Randomized bench for reference_router_wrapper against a packet-level reference model.
`timescale 1ns/1ps
module tb_reference_router_wrapper;

  localparam int          GAP   = 8;
  localparam int          CNT_W = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic clk_p = 1'b0;
  logic clk_n = 1'b1;
  logic reset = 1'b0;
  logic led;

  always #2.5 begin
    clk_p = ~clk_p;
    clk_n = ~clk_p;
  end

  reference_router_wrapper_if #(.CNT_W(CNT_W)) rt ();

  reference_router_wrapper #(
    .GAP(GAP), .LFSR_SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .fpga_sysclk_p(clk_p),
    .fpga_sysclk_n(clk_n),
    .reset(reset),
    .rt(rt.master),
    .led_heartbeat(led)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // packet-level model state
  int          e_idx;
  int          pkt;
  logic [15:0] m_lfsr;
  int          m_cnt [6];
  bit          m_valid;
  logic [4:0]  m_port;
  logic [31:0] m_dst;
  int          m_hb;
  bit          m_led;
  realtime     last_t;
  int          dut_vld_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] tmpl(input int k);
    case (k)
      0:       tmpl = 32'h0A020000;
      1:       tmpl = 32'h0A010000;
      2:       tmpl = 32'hC0A80000;
      3:       tmpl = 32'hAC1F0000;
      default: tmpl = 32'h08080000;
    endcase
  endfunction

  function automatic logic [4:0] lpm(input logic [31:0] dst);
    logic [31:0] pv [4];
    int          pl [4];
    int          best;
    logic [31:0] mask;
    pv[0] = 32'h0A000000; pl[0] = 8;
    pv[1] = 32'h0A010000; pl[1] = 16;
    pv[2] = 32'hC0A80000; pl[2] = 16;
    pv[3] = 32'hAC100000; pl[3] = 12;
    best = -1;
    lpm  = 5'b10000;
    for (int i = 0; i < 4; i++) begin
      mask = ~(32'hFFFFFFFF >> pl[i]);
      if ((dst & mask) == pv[i] && pl[i] > best) begin
        best = pl[i];
        lpm  = 5'(1 << i);
      end
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    int fb;
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    lfsr_next = 16'(((int'(x) << 1) & 16'hFFFF) | fb);
  endfunction

  task automatic tick(input bit rst, input logic [2:0] sel);
    int idx;
    int exp_cnt;
    reset      = rst;
    rt.cnt_sel = sel;
    @(posedge clk_p);
    #1;
    if (!rst) begin
      e_idx = 0; pkt = 0; m_lfsr = SEED; m_hb = 0; m_led = 0;
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_valid = 0; m_port = '0; m_dst = '0;
      last_t = 0.0;
    end else begin
      if (m_valid) begin
        for (int i = 0; i < 5; i++)
          if (m_port[i] && m_cnt[i] < SAT) m_cnt[i]++;
        if (m_cnt[5] < SAT) m_cnt[5]++;
        m_hb = (m_hb + 1) % 16;
        if (m_hb == 0) m_led = ~m_led;
      end
      idx = e_idx;
      e_idx++;
      m_valid = (idx >= GAP + 1) && ((idx - 2) % GAP == GAP - 1);
      if (m_valid) begin
        m_dst  = tmpl(pkt % 5) | {16'h0, m_lfsr};
        m_port = lpm(m_dst);
        m_lfsr = lfsr_next(m_lfsr);
        pkt++;
      end else begin
        m_port = '0;
        m_dst  = '0;
      end
    end
    exp_cnt = (sel < 6) ? m_cnt[sel] : 0;
    check("route_valid", {31'h0, rt.route_valid}, {31'h0, m_valid});
    check("route_port",  {27'h0, rt.route_port},  {27'h0, m_port});
    check("route_dst",   rt.route_dst,            m_dst);
    check("cnt_value",   32'(rt.cnt_value),       32'(exp_cnt));
`ifdef REFROUTER_HEARTBEAT_EN
    check("led", {31'h0, led}, {31'h0, m_led});
`else
    check("led", {31'h0, led}, 32'h0);
`endif
    if (rt.route_valid === 1'b1) begin
      dut_vld_seen++;
      if (last_t > 0.0) check("period_ns", 32'(int'($realtime - last_t)), 32'(GAP * 5));
      last_t = $realtime;
    end
  endtask

  task automatic peek(input logic [2:0] sel, input int exp, input string tag);
    rt.cnt_sel = sel;
    #0.2;
    check(tag, 32'(rt.cnt_value), 32'(exp));
  endtask

  task automatic run_high(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    rt.cnt_sel = '0;
    for (int i = 0; i < 10; i++) tick(1'b0, 3'($urandom_range(0, 7)));

    // first packet: edges 0..9 after release
    run_high(10);
    check("first_valid", {31'h0, rt.route_valid}, 32'h1);
    check("first_port",  {27'h0, rt.route_port},  32'h1);
    check("first_dst",   rt.route_dst,            32'h0A02ACE1);

    // five packets, counters visible one edge after the fifth
    run_high(33);
    for (int s = 0; s < 5; s++) peek(3'(s), 1, "cnt_one_each");
    peek(3'd5, 5, "cnt_total5");

    // reset the cycle after the third gen pulse
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd5);
    dut_vld_seen = 0;
    run_high(24);
    tick(1'b0, 3'd5);
    check("flush_vld_count", 32'(dut_vld_seen), 32'd2);
    peek(3'd5, 0, "cnt_cleared_total");
    peek(3'd0, 0, "cnt_cleared_p0");
    run_high(10);
    check("restart_dst", rt.route_dst, 32'h0A02ACE1);

    // 20 packets: saturation and empty selects
    run_high(153);
    peek(3'd5, 15, "cnt_sat_total");
    peek(3'd0, 4,  "cnt_p0_after20");
    peek(3'd6, 0,  "cnt_sel6");
    peek(3'd7, 0,  "cnt_sel7");
`ifdef REFROUTER_HEARTBEAT_EN
    check("led_after16", {31'h0, led}, 32'h1);
`else
    check("led_after16", {31'h0, led}, 32'h0);
`endif
    run_high(96);
    check("led_after32", {31'h0, led}, 32'h0);

    // random phase with occasional resets
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        int len;
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) tick(1'b0, 3'($urandom_range(0, 7)));
      end else begin
        tick(1'b1, 3'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
